// File: rtl/csel_serial_addsub_if.sv
// csel_serial_addsub_if: operand/result handshake bundle for the serial carry-select add/sub unit
interface csel_serial_addsub_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready, op_sub, c_in;
  logic             out_valid, out_ready, c_out, ovf, busy;
  logic [WIDTH-1:0] a, b, s;
  modport master(output in_valid, a, b, op_sub, c_in, out_ready,
                 input in_ready, out_valid, s, c_out, ovf, busy);
  modport slave(input in_valid, a, b, op_sub, c_in, out_ready,
                output in_ready, out_valid, s, c_out, ovf, busy);
endinterface

// File: rtl/csel_serial_addsub.sv
// csel_serial_addsub: slice-per-cycle carry-select add/subtract with valid/ready on both sides
module csel_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic clk,
  input logic rst,
  csel_serial_addsub_if.slave io
);
  localparam int N  = WIDTH / BLOCK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             sub_q, sub_d, cy_q, cy_d, c_out_q, c_out_d, ovf_q, ovf_d, ov_q, ov_d;
  logic [BLOCK-1:0] a_sl, b_sl, sum;
  logic [BLOCK:0]   s0, s1;
  logic             cy_nx, last;
  assign a_sl  = a_q[k_q*BLOCK +: BLOCK];
  assign b_sl  = b_q[k_q*BLOCK +: BLOCK];
  assign s0    = {1'b0, a_sl} + {1'b0, b_sl};
  assign s1    = {1'b0, a_sl} + {1'b0, b_sl} + 1'b1;
  assign sum   = cy_q ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
  assign cy_nx = cy_q ? s1[BLOCK] : s0[BLOCK];
  assign last  = k_q == KW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    k_d     = k_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        a_d     = io.a;
        b_d     = io.op_sub ? ~io.b : io.b;
        sub_d   = io.op_sub;
        cy_d    = io.op_sub ^ io.c_in;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        s_d[k_q*BLOCK +: BLOCK] = sum;
        cy_d = cy_nx;
        k_d  = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          ov_d    = 1'b1;
          c_out_d = sub_q ^ cy_nx;
          // sum[BLOCK-1] is the result MSB on the final slice
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[BLOCK-1] != a_q[WIDTH-1]);
        end
      end
      DONE: if (io.out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      k_q     <= k_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  assign io.in_ready  = state_q == IDLE;
  assign io.busy      = state_q == RUN;
  assign io.out_valid = ov_q;
  assign io.s         = s_q;
  assign io.c_out     = c_out_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_csel_serial_addsub.sv
// tb_csel_serial_addsub: directed and random checks of the serial add/sub against integer arithmetic
module tb_csel_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  csel_serial_addsub_if #(.WIDTH(16)) io();
  csel_serial_addsub #(.WIDTH(16), .BLOCK(4)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic msub, input logic mcin);
    logic [16:0] r;
    int sr;
    if (!msub) begin
      r  = {1'b0, ma} + {1'b0, mb} + 17'(mcin);
      sr = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
    end else begin
      r  = {1'b0, ma} - {1'b0, mb} - 17'(mcin);
      sr = int'($signed(ma)) - int'($signed(mb)) - int'(mcin);
    end
    return {(sr > 32767 || sr < -32768), r};
  endfunction
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb, input logic tsub, input logic tcin);
    @(negedge clk);
    chk("in_ready_idle", 32'(io.in_ready), 32'd1);
    io.a = ta; io.b = tb; io.op_sub = tsub; io.c_in = tcin; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask
  task automatic wait_result(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                             input logic tcin, input string tag);
    int cnt = 0;
    logic [17:0] m;
    while (!io.out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd4);
    m = model(ta, tb, tsub, tcin);
    chk({tag, "_s"}, 32'(io.s), 32'(m[15:0]));
    chk({tag, "_c_out"}, 32'(io.c_out), 32'(m[16]));
    chk({tag, "_ovf"}, 32'(io.ovf), 32'(m[17]));
  endtask
  task automatic op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                    input logic tcin, input int stall, input string tag);
    logic [17:0] m;
    m = model(ta, tb, tsub, tcin);
    launch(ta, tb, tsub, tcin);
    wait_result(ta, tb, tsub, tcin, tag);
    repeat (stall) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(io.out_valid), 32'd1);
      chk({tag, "_stall_s"}, 32'(io.s), 32'(m[15:0]));
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    chk({tag, "_release"}, 32'(io.out_valid), 32'd0);
    chk({tag, "_kept_s"}, 32'(io.s), 32'(m[15:0]));
  endtask
  initial begin
    logic [17:0] m;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.op_sub = 1'b0; io.c_in = 1'b0; io.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_outs", {io.s, 13'd0, io.c_out, io.ovf, io.out_valid, io.busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "add_ff_1");
    op(16'h0000, 16'h0001, 1'b1, 1'b0, 0, "sub_0_1");
    op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, "sub_8000_1");
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_7fff_1");
    op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, "add_ffff_cin");
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result(16'h1234, 16'h4321, 1'b0, 1'b0, "hold");
    m = model(16'h1234, 16'h4321, 1'b0, 1'b0);
    io.a = 16'hAAAA; io.b = 16'h5555; io.op_sub = 1'b1; io.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(io.out_valid), 32'd1);
      chk("hold_in_ready", 32'(io.in_ready), 32'd0);
      chk("hold_s", 32'(io.s), 32'(m[15:0]));
      chk("hold_flags", {30'd0, io.c_out, io.ovf}, {30'd0, m[16], m[17]});
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_queue_busy", 32'(io.busy), 32'd0);
    chk("no_queue_valid", 32'(io.out_valid), 32'd0);
    launch(16'hF0F0, 16'h0F0F, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_busy", 32'(io.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_outs", {io.s, 13'd0, io.c_out, io.ovf, io.out_valid, io.busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    op(16'h1111, 16'h2222, 1'b1, 1'b1, 2, "after_rst");
    for (int i = 0; i < 1000; i++)
      op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
